mem_port_arbiter: RTL and testbench

- Shares one single-port, word-addressed program/data memory between the instruction-fetch requester and the load/store (data) requester of the ARM core.
- Sits between the core's fetch/data interfaces and the memory array.
- Sequences each access through a fixed read latency, with one access outstanding at a time.
- Data has priority over fetch; an anti-starvation counter guarantees fetch progress.

---
 rtl/mem_port_arb_pkg.sv | 29 ++
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arb_pick.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//   owner_e : which requester owns the outstanding access
//   state_e : arbiter sequencing state
package mem_port_arb_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = 4;
  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned LAT_CNT_W   = 3;
  localparam int unsigned STARVE_W    = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Byte address to word address; the two low bits are dropped.
  function automatic logic [WORD_ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] byte_addr);
    return byte_addr[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals of the memory port arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives ready/rsp/mem_*)
//   master : environment view (core requesters plus memory array)
interface mem_port_arbiter_if;
  import mem_port_arb_pkg::*;

  logic                   if_valid;
  logic                   if_ready;
  logic [ADDR_W-1:0]      if_addr;
  logic                   if_rsp_valid;
  logic [DATA_W-1:0]      if_rdata;

  logic                   d_valid;
  logic                   d_ready;
  logic                   d_we;
  logic [BE_W-1:0]        d_be;
  logic [ADDR_W-1:0]      d_addr;
  logic [DATA_W-1:0]      d_wdata;
  logic                   d_rsp_valid;
  logic [DATA_W-1:0]      d_rdata;

  logic                   mem_en;
  logic                   mem_we;
  logic [BE_W-1:0]        mem_be;
  logic [WORD_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  modport slave (
    input  if_valid, if_addr, d_valid, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rsp_valid, if_rdata, d_ready, d_rsp_valid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_valid, if_addr, d_valid, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rsp_valid, if_rdata, d_ready, d_rsp_valid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arb_pick.sv
// Winner select between fetch and data plus the fetch starvation counter.
//   clk, reset : clock, async active-high reset
//   if_valid   : fetch request pending
//   d_valid    : data request pending
//   grant_en   : arbitration allowed this cycle (arbiter idle, not in reset)
//   grant_if   : fetch wins (combinational)
//   grant_d    : data wins (combinational)
module mem_port_arb_pick
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_valid,
  input  logic d_valid,
  input  logic grant_en,
  output logic grant_if,
  output logic grant_d
);

  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;
  logic                fetch_pri;

  assign fetch_pri = (starve_q >= STARVE_W'(STARVE_MAX));

  // Data normally wins; a starved fetch overrides it.
  always_comb begin
    grant_if = grant_en & if_valid & (~d_valid | fetch_pri);
    grant_d  = grant_en & d_valid & ~grant_if;
  end

  // Counts arbitration rounds fetch lost to data; saturates at all-ones.
  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_d && if_valid && (starve_q != {STARVE_W{1'b1}})) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word-addressed memory between instruction fetch and
// load/store requesters, one access outstanding, fixed read latency LAT.
//   clk, reset : clock, async active-high reset
//   bus        : fetch request/response, data request/response, memory port
//   perf_*     : grant/conflict counters, present only with MEM_PORT_ARB_PERF_EN
// Ready and mem_* outputs are combinational from the grant; responses and
// read data are registered.
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned LAT        = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
`ifdef MEM_PORT_ARB_PERF_EN
  ,
  output logic [31:0]        perf_if_grants,
  output logic [31:0]        perf_d_grants,
  output logic [31:0]        perf_conflicts
`endif
);

  state_e                 state_q, state_d;
  owner_e                 owner_q, owner_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   store_q, store_d;
  logic                   if_rsp_valid_q, if_rsp_valid_d;
  logic                   d_rsp_valid_q, d_rsp_valid_d;
  logic [DATA_W-1:0]      if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]      d_rdata_q, d_rdata_d;

  logic                   grant_en;
  logic                   grant_if;
  logic                   grant_d;

  logic                   mem_en_c;
  logic                   mem_we_c;
  logic [BE_W-1:0]        mem_be_c;
  logic [WORD_ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0]      mem_wdata_c;

  logic                   unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

  // Reset gates arbitration so ready and mem_en drop immediately.
  assign grant_en = (state_q == IDLE) & ~reset;

  mem_port_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk      (clk),
    .reset    (reset),
    .if_valid (bus.if_valid),
    .d_valid  (bus.d_valid),
    .grant_en (grant_en),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  // Next-state and memory-side drive.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    store_d        = store_q;
    if_rsp_valid_d = 1'b0;
    d_rsp_valid_d  = 1'b0;
    if_rdata_d     = if_rdata_q;
    d_rdata_d      = d_rdata_q;
    mem_en_c       = 1'b0;
    mem_we_c       = 1'b0;
    mem_be_c       = '0;
    mem_addr_c     = '0;
    mem_wdata_c    = '0;

    case (state_q)
      IDLE: begin
        if (grant_if) begin
          mem_en_c   = 1'b1;
          mem_be_c   = 4'hF;
          mem_addr_c = word_addr(bus.if_addr);
          owner_d    = OWN_IF;
          store_d    = 1'b0;
          cnt_d      = LAT_CNT_W'(LAT);
          state_d    = WAIT;
        end else if (grant_d) begin
          mem_en_c    = 1'b1;
          mem_we_c    = bus.d_we;
          mem_be_c    = bus.d_we ? bus.d_be : 4'hF;
          mem_addr_c  = word_addr(bus.d_addr);
          mem_wdata_c = bus.d_we ? bus.d_wdata : '0;
          owner_d     = OWN_D;
          store_d     = bus.d_we;
          cnt_d       = LAT_CNT_W'(LAT);
          state_d     = WAIT;
        end
      end
      WAIT: begin
        // Last latency cycle: mem_rdata is valid now, respond next cycle.
        if (cnt_q == LAT_CNT_W'(1)) begin
          if (owner_q == OWN_IF) begin
            if_rsp_valid_d = 1'b1;
            if_rdata_d     = bus.mem_rdata;
          end else if (owner_q == OWN_D) begin
            d_rsp_valid_d  = 1'b1;
            d_rdata_d      = store_q ? '0 : bus.mem_rdata;
          end
          owner_d = OWN_NONE;
          store_d = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_d_q, perf_d_d;
  logic [31:0] perf_conf_q, perf_conf_d;

  // Free-running wrap-around event counters.
  always_comb begin
    perf_if_d   = perf_if_q + 32'(grant_if);
    perf_d_d    = perf_d_q + 32'(grant_d);
    perf_conf_d = perf_conf_q + 32'(grant_en & bus.if_valid & bus.d_valid);
  end

  assign perf_if_grants = perf_if_q;
  assign perf_d_grants  = perf_d_q;
  assign perf_conflicts = perf_conf_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      owner_q        <= OWN_NONE;
      cnt_q          <= '0;
      store_q        <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      if_rdata_q     <= '0;
      d_rdata_q      <= '0;
`ifdef MEM_PORT_ARB_PERF_EN
      perf_if_q      <= '0;
      perf_d_q       <= '0;
      perf_conf_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      cnt_q          <= cnt_d;
      store_q        <= store_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
      if_rdata_q     <= if_rdata_d;
      d_rdata_q      <= d_rdata_d;
`ifdef MEM_PORT_ARB_PERF_EN
      perf_if_q      <= perf_if_d;
      perf_d_q       <= perf_d_d;
      perf_conf_q    <= perf_conf_d;
`endif
    end
  end

  assign bus.if_ready     = grant_if;
  assign bus.d_ready      = grant_d;
  assign bus.if_rsp_valid = if_rsp_valid_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.d_rsp_valid  = d_rsp_valid_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.mem_en       = mem_en_c;
  assign bus.mem_we       = mem_we_c;
  assign bus.mem_be       = mem_be_c;
  assign bus.mem_addr     = mem_addr_c;
  assign bus.mem_wdata    = mem_wdata_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with LAT=1, one with LAT=3,
// each with a behavioural memory; responses checked against a scoreboard.
module tb_mem_port_arbiter;
  import mem_port_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [31:0] q_if_a[$];
  logic [31:0] q_d_a[$];
  logic [31:0] q_if_b[$];

  mem_port_arbiter_if bus_a();
  mem_port_arbiter_if bus_b();

`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] pa_if, pa_d, pa_c, pb_if, pb_d, pb_c;
`endif

  mem_port_arbiter #(.LAT(1), .STARVE_MAX(4)) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_a.slave)
`ifdef MEM_PORT_ARB_PERF_EN
    , .perf_if_grants(pa_if), .perf_d_grants(pa_d), .perf_conflicts(pa_c)
`endif
  );

  mem_port_arbiter #(.LAT(3), .STARVE_MAX(4)) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_b.slave)
`ifdef MEM_PORT_ARB_PERF_EN
    , .perf_if_grants(pb_if), .perf_d_grants(pb_d), .perf_conflicts(pb_c)
`endif
  );

  function automatic logic [31:0] init_word(input int unsigned w);
    if (w == 2) return 32'hEB00000A;
    return 32'h1000_0000 + 32'(w);
  endfunction

  // Behavioural memories; non-read cycles push garbage so a wrong sample cycle shows up.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] rd_a;
  logic [31:0] pipe_b [3];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= init_word(i);
        mem_b[i] <= init_word(i);
      end
      rd_a <= 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) pipe_b[i] <= 32'hDEAD_BEEF;
    end else begin
      if (bus_a.mem_en && bus_a.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus_a.mem_be[b]) mem_a[bus_a.mem_addr[7:0]][8*b +: 8] <= bus_a.mem_wdata[8*b +: 8];
      end
      rd_a <= (bus_a.mem_en && !bus_a.mem_we) ? mem_a[bus_a.mem_addr[7:0]] : 32'hDEAD_BEEF;
      pipe_b[0] <= (bus_b.mem_en && !bus_b.mem_we) ? mem_b[bus_b.mem_addr[7:0]] : 32'hDEAD_BEEF;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
    end
  end

  assign bus_a.mem_rdata = rd_a;
  assign bus_b.mem_rdata = pipe_b[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Response scoreboard.
  always @(negedge clk) begin
    if (bus_a.if_rsp_valid) begin
      check("a_if_rsp_expected", 32'(q_if_a.size() != 0), 32'd1);
      if (q_if_a.size() != 0) check("a_if_rdata", bus_a.if_rdata, q_if_a.pop_front());
    end
    if (bus_a.d_rsp_valid) begin
      check("a_d_rsp_expected", 32'(q_d_a.size() != 0), 32'd1);
      if (q_d_a.size() != 0) check("a_d_rdata", bus_a.d_rdata, q_d_a.pop_front());
    end
    if (bus_b.if_rsp_valid) begin
      check("b_if_rsp_expected", 32'(q_if_b.size() != 0), 32'd1);
      if (q_if_b.size() != 0) check("b_if_rdata", bus_b.if_rdata, q_if_b.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int g;
    rst = 1'b1;
    bus_a.if_valid = 1'b0; bus_a.if_addr = '0; bus_a.d_valid = 1'b0; bus_a.d_we = 1'b0;
    bus_a.d_be = '0; bus_a.d_addr = '0; bus_a.d_wdata = '0;
    bus_b.if_valid = 1'b0; bus_b.if_addr = '0; bus_b.d_valid = 1'b0; bus_b.d_we = 1'b0;
    bus_b.d_be = '0; bus_b.d_addr = '0; bus_b.d_wdata = '0;

    // Reset state
    @(negedge clk);
    check("rst_if_ready", 32'(bus_a.if_ready), 32'd0);
    check("rst_d_ready", 32'(bus_a.d_ready), 32'd0);
    check("rst_mem_en", 32'(bus_a.mem_en), 32'd0);
    check("rst_mem_we", 32'(bus_a.mem_we), 32'd0);
    check("rst_mem_be", 32'(bus_a.mem_be), 32'd0);
    check("rst_mem_addr", 32'(bus_a.mem_addr), 32'd0);
    check("rst_rsp", 32'({bus_a.if_rsp_valid, bus_a.d_rsp_valid}), 32'd0);
    check("rst_rdata", bus_a.if_rdata | bus_a.d_rdata, 32'd0);
    cyc();
    rst = 1'b0;

    // Fetch only, LAT=1
    cyc();
    bus_a.if_valid = 1'b1; bus_a.if_addr = 32'h8;
    @(negedge clk);
    check("f_if_ready", 32'(bus_a.if_ready), 32'd1);
    check("f_d_ready", 32'(bus_a.d_ready), 32'd0);
    check("f_mem_en", 32'(bus_a.mem_en), 32'd1);
    check("f_mem_addr", 32'(bus_a.mem_addr), 32'h2);
    check("f_mem_we", 32'(bus_a.mem_we), 32'd0);
    check("f_mem_be", 32'(bus_a.mem_be), 32'hF);
    if (bus_a.if_ready) q_if_a.push_back(init_word(2));
    cyc();
    bus_a.if_valid = 1'b0;
    @(negedge clk);
    check("f_rsp_t1", 32'(bus_a.if_rsp_valid), 32'd0);
    check("f_busy_mem_en", 32'(bus_a.mem_en), 32'd0);
    cyc();
    @(negedge clk);
    check("f_rsp_t2", 32'(bus_a.if_rsp_valid), 32'd1);
    cyc();
    @(negedge clk);
    check("f_rsp_pulse", 32'(bus_a.if_rsp_valid), 32'd0);
    check("f_rdata_hold", bus_a.if_rdata, 32'hEB00000A);

    // Simultaneous requests: data first, fetch two cycles later
    cyc();
    bus_a.if_valid = 1'b1; bus_a.if_addr = 32'h0;
    bus_a.d_valid = 1'b1; bus_a.d_we = 1'b0; bus_a.d_addr = 32'hFC;
    @(negedge clk);
    check("sim_d_ready", 32'(bus_a.d_ready), 32'd1);
    check("sim_if_ready", 32'(bus_a.if_ready), 32'd0);
    check("sim_mem_addr", 32'(bus_a.mem_addr), 32'h3F);
    if (bus_a.d_ready) q_d_a.push_back(init_word(32'h3F));
    cyc();
    bus_a.d_valid = 1'b0;
    @(negedge clk);
    check("sim_if_ready_t1", 32'(bus_a.if_ready), 32'd0);
    cyc();
    @(negedge clk);
    check("sim_if_ready_t2", 32'(bus_a.if_ready), 32'd1);
    check("sim_if_mem_addr", 32'(bus_a.mem_addr), 32'h0);
    if (bus_a.if_ready) q_if_a.push_back(init_word(0));
    cyc();
    bus_a.if_valid = 1'b0;
    cyc();

    // Store, then read back the merged word
    cyc();
    bus_a.d_valid = 1'b1; bus_a.d_we = 1'b1; bus_a.d_addr = 32'hD0;
    bus_a.d_be = 4'b0001; bus_a.d_wdata = 32'h5A;
    @(negedge clk);
    check("st_d_ready", 32'(bus_a.d_ready), 32'd1);
    check("st_mem_we", 32'(bus_a.mem_we), 32'd1);
    check("st_mem_addr", 32'(bus_a.mem_addr), 32'h34);
    check("st_mem_be", 32'(bus_a.mem_be), 32'h1);
    check("st_mem_wdata", bus_a.mem_wdata, 32'h5A);
    if (bus_a.d_ready) q_d_a.push_back(32'h0);
    cyc();
    bus_a.d_valid = 1'b0; bus_a.d_we = 1'b0; bus_a.d_be = '0; bus_a.d_wdata = '0;
    cyc();
    bus_a.d_valid = 1'b1; bus_a.d_addr = 32'hD0;
    @(negedge clk);
    check("st_rsp", 32'(bus_a.d_rsp_valid), 32'd1);
    check("ld_d_ready", 32'(bus_a.d_ready), 32'd1);
    check("ld_mem_we", 32'(bus_a.mem_we), 32'd0);
    if (bus_a.d_ready) q_d_a.push_back((init_word(32'h34) & 32'hFFFF_FF00) | 32'h5A);
    cyc();
    bus_a.d_valid = 1'b0;
    cyc();
    cyc();

    // Starvation: both valid continuously, expect D D D D F D D D D F
    bus_a.if_valid = 1'b1; bus_a.if_addr = 32'h10;
    bus_a.d_valid = 1'b1; bus_a.d_we = 1'b0; bus_a.d_addr = 32'h20;
    k = 0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      @(negedge clk);
      if (bus_a.if_ready || bus_a.d_ready) begin
        check($sformatf("starve_one_ready_%0d", k), 32'(bus_a.if_ready & bus_a.d_ready), 32'd0);
        check($sformatf("starve_grant_if_%0d", k), 32'(bus_a.if_ready), 32'((k % 5) == 4));
        if (bus_a.if_ready) q_if_a.push_back(init_word(4));
        else q_d_a.push_back(init_word(8));
        k++;
      end
      cyc();
    end
    check("starve_grant_count", 32'(k), 32'd10);
    bus_a.if_valid = 1'b0; bus_a.d_valid = 1'b0;
    cyc();
    cyc();

    // LAT=3 back-to-back fetches
    bus_b.if_valid = 1'b1; bus_b.if_addr = 32'h40;
    g = 0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("lat3_ready_%0d", c), 32'(bus_b.if_ready), 32'(c == 0 || c == 4 || c == 8));
      check($sformatf("lat3_rsp_%0d", c), 32'(bus_b.if_rsp_valid), 32'(c == 4 || c == 8 || c == 12));
      if (bus_b.if_ready) begin
        q_if_b.push_back(init_word(16 + g));
        g++;
      end
      cyc();
      if (g == 3) bus_b.if_valid = 1'b0;
      else bus_b.if_addr = 32'h40 + 32'(4 * g);
    end

    // Reset one cycle after a grant
    bus_a.if_valid = 1'b1; bus_a.if_addr = 32'h8;
    @(negedge clk);
    check("rw_if_ready", 32'(bus_a.if_ready), 32'd1);
    cyc();
    rst = 1'b1;
    #1;
    check("rw_if_ready_in_rst", 32'(bus_a.if_ready), 32'd0);
    check("rw_mem_en", 32'(bus_a.mem_en), 32'd0);
    check("rw_mem_addr", 32'(bus_a.mem_addr), 32'd0);
    check("rw_if_rdata", bus_a.if_rdata, 32'd0);
    check("rw_d_rdata", bus_a.d_rdata, 32'd0);
    cyc();
    @(negedge clk);
    check("rw_no_rsp", 32'({bus_a.if_rsp_valid, bus_a.d_rsp_valid}), 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rw_post_ready", 32'(bus_a.if_ready), 32'd1);
    check("rw_post_mem_addr", 32'(bus_a.mem_addr), 32'h2);
    if (bus_a.if_ready) q_if_a.push_back(init_word(2));
    cyc();
    bus_a.if_valid = 1'b0;
    cyc();
    cyc();

    check("q_if_a_empty", 32'(q_if_a.size()), 32'd0);
    check("q_d_a_empty", 32'(q_d_a.size()), 32'd0);
    check("q_if_b_empty", 32'(q_if_b.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
